// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: 32-step shift-add multiplier and restoring divider on magnitudes.
// Latency: fixed 33 cycles from accepted start to done; start is ignored while busy.
// Backpressure: none; done is a single-cycle pulse and the result holds until the next done.
module muldiv_unit #(
    parameter int D_WIDTH       = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [2:0]               funct3,
    input  logic [D_WIDTH-1:0]       op_a,
    input  logic [D_WIDTH-1:0]       op_b,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic                     busy,
    output logic                     done,
    output logic [D_WIDTH-1:0]       result,
    output logic [ADDRESS_WIDTH-1:0] wr_addr,
    output logic                     wr_en
);

    localparam int CW = $clog2(D_WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                   state;
    logic [CW-1:0]            iter;
    logic [2:0]               op_q;
    logic                     a_neg;
    logic                     b_neg;
    logic                     div_zero;
    logic [D_WIDTH-1:0]       a_raw;
    logic [D_WIDTH-1:0]       b_mag;
    logic [D_WIDTH-1:0]       hi;
    logic [D_WIDTH-1:0]       lo;
    logic [D_WIDTH-1:0]       result_q;
    logic [ADDRESS_WIDTH-1:0] rd_q;
    logic [ADDRESS_WIDTH-1:0] wr_addr_q;
    logic                     busy_q;
    logic                     done_q;

    // Operand signedness and magnitudes at the accepting edge
    logic               a_sgn;
    logic               b_sgn;
    logic               in_a_neg;
    logic               in_b_neg;
    logic [D_WIDTH-1:0] a_mag_in;
    logic [D_WIDTH-1:0] b_mag_in;

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin a_sgn = 1'b1; b_sgn = 1'b1; end
            3'b010:                         begin a_sgn = 1'b1; b_sgn = 1'b0; end
            default:                        begin a_sgn = 1'b0; b_sgn = 1'b0; end
        endcase
        in_a_neg = a_sgn & op_a[D_WIDTH-1];
        in_b_neg = b_sgn & op_b[D_WIDTH-1];
        a_mag_in = in_a_neg ? (~op_a + 1'b1) : op_a;
        b_mag_in = in_b_neg ? (~op_b + 1'b1) : op_b;
    end

    // One iteration step. Multiply: {hi,lo} is product/multiplier, b_mag the multiplicand.
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    logic [D_WIDTH:0]   mul_sum;
    logic [D_WIDTH:0]   div_sh;
    logic [D_WIDTH:0]   div_diff;
    logic               div_ge;
    logic [D_WIDTH-1:0] hi_n;
    logic [D_WIDTH-1:0] lo_n;

    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, b_mag} : {(D_WIDTH+1){1'b0}});
        div_sh   = {hi, lo[D_WIDTH-1]};
        div_ge   = (div_sh >= {1'b0, b_mag});
        div_diff = div_sh - {1'b0, b_mag};
        if (op_q[2]) begin
            hi_n = div_ge ? div_diff[D_WIDTH-1:0] : div_sh[D_WIDTH-1:0];
            lo_n = {lo[D_WIDTH-2:0], div_ge};
        end else begin
            hi_n = mul_sum[D_WIDTH:1];
            lo_n = {mul_sum[0], lo[D_WIDTH-1:1]};
        end
    end

    // Sign correction and special cases, evaluated while in DONE
    logic [2*D_WIDTH-1:0] prod_fix;
    logic [D_WIDTH-1:0]   quot_fix;
    logic [D_WIDTH-1:0]   rem_fix;
    logic [D_WIDTH-1:0]   final_val;

    always_comb begin
        prod_fix = (a_neg ^ b_neg) ? (~{hi, lo} + 1'b1) : {hi, lo};
        if (div_zero)
            quot_fix = {D_WIDTH{1'b1}};
        else
            quot_fix = (a_neg ^ b_neg) ? (~lo + 1'b1) : lo;
        if (div_zero)
            rem_fix = a_raw;
        else
            rem_fix = a_neg ? (~hi + 1'b1) : hi;
        case (op_q)
            3'b000:                 final_val = prod_fix[D_WIDTH-1:0];
            3'b001, 3'b010, 3'b011: final_val = prod_fix[2*D_WIDTH-1:D_WIDTH];
            3'b100, 3'b101:         final_val = quot_fix;
            default:                final_val = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            iter      <= '0;
            op_q      <= '0;
            a_neg     <= 1'b0;
            b_neg     <= 1'b0;
            div_zero  <= 1'b0;
            a_raw     <= '0;
            b_mag     <= '0;
            hi        <= '0;
            lo        <= '0;
            result_q  <= '0;
            rd_q      <= '0;
            wr_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q     <= funct3;
                        a_neg    <= in_a_neg;
                        b_neg    <= in_b_neg;
                        div_zero <= (op_b == '0);
                        a_raw    <= op_a;
                        b_mag    <= b_mag_in;
                        hi       <= '0;
                        lo       <= a_mag_in;
                        rd_q     <= rd_addr;
                        iter     <= '0;
                        busy_q   <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    hi   <= hi_n;
                    lo   <= lo_n;
                    iter <= iter + 1'b1;
                    if (iter == CW'(D_WIDTH - 1)) begin
                        // wr_addr only moves when a new result appears
                        wr_addr_q <= rd_q;
                        done_q    <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    result_q <= final_val;
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = (state == DONE) ? final_val : result_q;
    assign wr_addr = wr_addr_q;
    assign wr_en   = done_q && (wr_addr_q != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: every RV32M op, corner cases, abort and start-while-busy.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_addr;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  wr_addr;
    logic        wr_en;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] prev_res;

    muldiv_unit #(.D_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .funct3  (funct3),
        .op_a    (op_a),
        .op_b    (op_b),
        .rd_addr (rd_addr),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .wr_addr (wr_addr),
        .wr_en   (wr_en)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Caller must be at a negedge in an idle cycle. Returns at the negedge of cycle 33.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input bit poke,
                          input string tag);
        int done_cyc = -1;
        int nd = 0;
        int nb = 0;
        int nw = 0;
        logic [31:0] res_s = '0;
        logic [4:0]  wa_s = '0;
        check_eq({tag, " idle_busy"}, {63'd0, busy}, 64'd0);
        check_eq({tag, " idle_hold"}, {32'd0, result}, {32'd0, prev_res});
        funct3 = f; op_a = a; op_b = b; rd_addr = rd; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; funct3 = ~f; op_a = 32'hDEADBEEF; op_b = 32'h0; rd_addr = ~rd;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            if (done) begin nd++; done_cyc = c; end
            if (busy) nb++;
            if (wr_en) nw++;
            if (c == 33) begin res_s = result; wa_s = wr_addr; end
            if (poke && c == 5) begin
                start = 1'b1; funct3 = 3'b000; op_a = 32'd1; op_b = 32'd1; rd_addr = 5'd9;
            end
            if (poke && c == 6) start = 1'b0;
        end
        check_eq({tag, " done_cycle"}, 64'(done_cyc), 64'd33);
        check_eq({tag, " done_count"}, 64'(nd), 64'd1);
        check_eq({tag, " busy_cycles"}, 64'(nb), 64'd33);
        check_eq({tag, " result"}, {32'd0, res_s}, {32'd0, exp});
        check_eq({tag, " wr_addr"}, {59'd0, wa_s}, {59'd0, rd});
        check_eq({tag, " wr_en_count"}, 64'(nw), (rd != 5'd0) ? 64'd1 : 64'd0);
        prev_res = exp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_addr = '0;
        prev_res = '0;
        repeat (3) @(negedge clk);
        check_eq("rst busy",    {63'd0, busy},    64'd0);
        check_eq("rst done",    {63'd0, done},    64'd0);
        check_eq("rst wr_en",   {63'd0, wr_en},   64'd0);
        check_eq("rst result",  {32'd0, result},  64'd0);
        check_eq("rst wr_addr", {59'd0, wr_addr}, 64'd0);

        // Start in the first cycle after reset deasserts
        rst = 1'b0;
        run_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 1'b0, "mul");
        @(negedge clk); run_op(3'b001, 32'h80000000, 32'h80000000, 5'd1, 32'h40000000, 1'b0, "mulh");
        @(negedge clk); run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 1'b0, "mulhu");
        @(negedge clk); run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF, 1'b0, "mulhsu");
        @(negedge clk); run_op(3'b001, 32'hFFFFFFFF, 32'd2, 5'd4, 32'hFFFFFFFF, 1'b0, "mulh_neg");
        @(negedge clk); run_op(3'b100, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFD, 1'b0, "div");
        @(negedge clk); run_op(3'b110, 32'hFFFFFFF9, 32'd2, 5'd7, 32'hFFFFFFFF, 1'b0, "rem");
        @(negedge clk); run_op(3'b100, 32'd7, 32'hFFFFFFFE, 5'd8, 32'hFFFFFFFD, 1'b0, "div_negb");
        @(negedge clk); run_op(3'b110, 32'd7, 32'hFFFFFFFE, 5'd9, 32'd1, 1'b0, "rem_negb");
        @(negedge clk); run_op(3'b101, 32'd100, 32'd7, 5'd10, 32'd14, 1'b0, "divu");
        @(negedge clk); run_op(3'b111, 32'd100, 32'd7, 5'd11, 32'd2, 1'b0, "remu");
        @(negedge clk); run_op(3'b101, 32'd5, 32'd0, 5'd12, 32'hFFFFFFFF, 1'b0, "divu_zero");
        @(negedge clk); run_op(3'b111, 32'd5, 32'd0, 5'd13, 32'd5, 1'b0, "remu_zero");
        @(negedge clk); run_op(3'b100, 32'hFFFFFFFB, 32'd0, 5'd14, 32'hFFFFFFFF, 1'b0, "div_zero");
        @(negedge clk); run_op(3'b110, 32'hFFFFFFFB, 32'd0, 5'd15, 32'hFFFFFFFB, 1'b0, "rem_zero");
        @(negedge clk); run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 1'b0, "div_ovf");
        @(negedge clk); run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0, 1'b0, "rem_ovf");
        @(negedge clk); run_op(3'b101, 32'd100, 32'd7, 5'd3, 32'd14, 1'b1, "busy_start");
        @(negedge clk); run_op(3'b000, 32'd6, 32'd7, 5'd0, 32'd42, 1'b0, "rd_zero");

        // Abort during CALC: reset high in cycle 10
        @(negedge clk);
        funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; rd_addr = 5'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 10; c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort busy",   {63'd0, busy},   64'd0);
        check_eq("abort result", {32'd0, result}, 64'd0);
        rst = 1'b0;
        begin
            int nd = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (done || wr_en) nd++;
            end
            check_eq("abort no_done", 64'(nd), 64'd0);
        end
        prev_res = '0;
        run_op(3'b111, 32'd100, 32'd7, 5'd20, 32'd2, 1'b0, "after_abort");

        @(negedge clk);
        check_eq("final busy", {63'd0, busy},   64'd0);
        check_eq("final done", {63'd0, done},   64'd0);
        check_eq("final hold", {32'd0, result}, 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter D_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 5, destination register address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-006 SHALL have port funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port op_a  input  D_WIDTH  rs1 value (dout1 of register file).
REQ-008 SHALL have port op_b  input  D_WIDTH  rs2 value (dout2 of register file).
REQ-009 SHALL have port rd_addr  input  ADDRESS_WIDTH  destination register.
REQ-010 SHALL have port busy  output  1  high in CALC and DONE.
REQ-011 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-012 SHALL have port result  output  D_WIDTH  operation result, drives register file din.
REQ-013 SHALL have port wr_addr  output  ADDRESS_WIDTH  latched rd_addr, drives register file wr_addr.
REQ-014 SHALL have port wr_en  output  1  done AND (wr_addr != 0), drives register file wr_en.

Function
REQ-015 SHALL implement states IDLE, CALC, DONE; IDLE->CALC on start, CALC->DONE after exactly 32 iterations, DONE->IDLE unconditionally.
REQ-016 SHALL latch funct3, op_a, op_b, rd_addr at the edge that accepts start; later input changes SHALL not affect the operation.
REQ-017 SHALL have fixed latency for every op: start high in cycle 0 -> CALC cycles 1..32 -> DONE/done=1 in cycle 33 -> IDLE in cycle 34; no early termination.
REQ-018 SHALL ignore start while busy=1; start in cycle 34 (IDLE) SHALL be accepted.
REQ-019 SHALL compute with an iterative unsigned 32-step shift-add multiplier and restoring divider on operand magnitudes, applying sign correction in DONE.
REQ-020 SHALL treat MUL/MULH/DIV/REM operands as signed, MULHU/DIVU/REMU as unsigned, MULHSU as op_a signed and op_b unsigned.
REQ-021 SHALL return low 32 bits of the 64-bit product for MUL and high 32 bits for MULH/MULHSU/MULHU.
REQ-022 SHALL round DIV toward zero; REM sign SHALL equal dividend sign.
REQ-023 SHALL on divide by zero return quotient 0xFFFFFFFF (DIV, DIVU) and remainder = op_a (REM, REMU).
REQ-024 SHALL on signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF) return DIV 0x80000000, REM 0.
REQ-025 SHALL hold result and wr_addr stable from DONE until the next DONE.
REQ-026 SHALL assert done for exactly one cycle per accepted start, including when wr_addr=0 (wr_en stays 0).

Reset
REQ-027 SHALL on rst force state IDLE, busy=0, done=0, wr_en=0, result=0, wr_addr=0.
REQ-028 SHALL give rst priority over start and over any in-flight operation; an aborted operation SHALL never produce done.
REQ-029 SHALL accept start in the first cycle after rst deasserts.

Verification
REQ-030 SHALL verify MUL op_a=7, op_b=0xFFFFFFFD, rd_addr=5 -> cycle 33: done=1, wr_en=1, wr_addr=5, result=0xFFFFFFEB; busy=1 cycles 1..33.
REQ-031 SHALL verify MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032 SHALL verify DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM 0xFFFFFFF9/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-033 SHALL verify DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
REQ-034 SHALL verify rst high in cycle 10 of CALC -> next cycle busy=0, no done thereafter; fresh start then completes normally in 33 cycles.
REQ-035 SHALL verify start with new operands in cycle 5 -> ignored, original result delivered; rd_addr=0 op -> done=1, wr_en=0.
